// File: rtl/ws2812b_pkg.sv
// Shared types and 40 MHz timing constants for the WS2812B ring driver.
package ws2812b_pkg;

    localparam int CLK_MHZ      = 40;
    localparam int N_LEDS       = 12;
    localparam int BITS_PER_LED = 24;

    localparam logic [5:0]  T0H    = 6'(400 * CLK_MHZ / 1000);
    localparam logic [5:0]  T1H    = 6'(800 * CLK_MHZ / 1000);
    localparam logic [5:0]  TBIT   = 6'(1250 * CLK_MHZ / 1000);
    localparam logic [11:0] TLATCH = 12'(60 * CLK_MHZ);

    localparam logic [3:0] LAST_LED = 4'(N_LEDS - 1);
    localparam logic [4:0] LAST_BIT = 5'(BITS_PER_LED - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

    // All three channels carry the same byte, so only the position within
    // the byte matters; bits go out MSB first.
    function automatic logic frame_bit(input logic lit, input logic [7:0] value,
                                       input logic [4:0] bit_idx);
        return lit & value[~bit_idx[2:0]];
    endfunction

endpackage

// File: rtl/ws2812b_if.sv
// Request/status bundle between the encoder controller and the ring driver.
interface ws2812b_if;
    import ws2812b_pkg::*;

    logic              refresh;
    logic [N_LEDS-1:0] led_mask;
    logic [7:0]        intensity;
    logic              led_data;
    logic              busy;

    modport master (
        output refresh, led_mask, intensity,
        input  led_data, busy
    );

    modport slave (
        input  refresh, led_mask, intensity,
        output led_data, busy
    );

endinterface

// File: rtl/ws2812b_bit_encoder.sv
// Produces one WS2812B bit waveform per start strobe; owns the per-bit counter.
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
(
    input  logic clk,
    input  logic res_n,
    input  logic start,
    input  logic bit_val,
    output logic wave,
    output logic high_end,
    output logic done
);

    logic [5:0] cnt;
    logic       active;
    logic [5:0] high_len;

    assign high_len = bit_val ? T1H : T0H;
    assign high_end = active && (cnt == high_len - 6'd1);
    assign done     = active && (cnt == TBIT - 6'd1);

    // Per-bit counter and registered output level; the output lags the
    // counter by one clock so the line rises on the edge after start.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt    <= '0;
            active <= 1'b0;
            wave   <= 1'b0;
        end else begin
            wave <= active && (cnt < high_len);
            if (start) begin
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (cnt == TBIT - 6'd1) begin
                    cnt    <= '0;
                    active <= 1'b0;
                end else begin
                    cnt <= cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ws2812b_driver.sv
// Frame sequencer for the 12-LED ring: snapshot, bit/LED walk, latch gap.
module ws2812b_driver
    import ws2812b_pkg::*;
(
    input  logic     clk,
    input  logic     res_n,
    ws2812b_if.slave bus
);

    state_t            state, state_nxt;
    logic [11:0]       cycle_cnt;
    logic [N_LEDS-1:0] snap_mask;
    logic [7:0]        snap_int;
    logic [3:0]        led_idx;
    logic [4:0]        bit_idx;
    logic              pending;
    logic              busy_q;
    logic              start;
    logic              take_snap;
    logic              cur_bit;
    logic              last_bit;
    logic              high_end;
    logic              done;
    logic              wave;

    assign cur_bit  = frame_bit(snap_mask[led_idx], snap_int, bit_idx);
    assign last_bit = (bit_idx == LAST_BIT) && (led_idx == LAST_LED);

    assign bus.led_data = wave;
    assign bus.busy     = busy_q;

    ws2812b_bit_encoder u_enc (
        .clk      (clk),
        .res_n    (res_n),
        .start    (start),
        .bit_val  (cur_bit),
        .wave     (wave),
        .high_end (high_end),
        .done     (done)
    );

    // Next-state decode; start and take_snap are issued on the edge that enters HIGH.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        take_snap = 1'b0;
        case (state)
            IDLE: begin
                if (bus.refresh) begin
                    state_nxt = HIGH;
                    start     = 1'b1;
                    take_snap = 1'b1;
                end
            end
            HIGH: begin
                if (high_end) state_nxt = LOW;
            end
            LOW: begin
                if (done) begin
                    if (last_bit) begin
                        state_nxt = LATCH;
                    end else begin
                        state_nxt = HIGH;
                        start     = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (cycle_cnt == TLATCH - 12'd1) begin
                    if (pending || bus.refresh) begin
                        state_nxt = HIGH;
                        start     = 1'b1;
                        take_snap = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = LATCH;
        endcase
    end

    // State register and cycle counter; the counter restarts on every state change.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= LATCH;
            cycle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cycle_cnt <= '0;
            end else if (state != IDLE) begin
                cycle_cnt <= cycle_cnt + 12'd1;
            end
        end
    end

    // Snapshot, bit/LED position, pending request and busy flag.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            snap_mask <= '0;
            snap_int  <= '0;
            led_idx   <= '0;
            bit_idx   <= '0;
            pending   <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            busy_q <= (state != IDLE);
            if (take_snap) begin
                snap_mask <= bus.led_mask;
                snap_int  <= bus.intensity;
                led_idx   <= '0;
                bit_idx   <= '0;
            end else if (state == LOW && done) begin
                if (bit_idx == LAST_BIT) begin
                    bit_idx <= '0;
                    led_idx <= (led_idx == LAST_LED) ? 4'd0 : led_idx + 4'd1;
                end else begin
                    bit_idx <= bit_idx + 5'd1;
                end
            end
            if (take_snap) begin
                pending <= 1'b0;
            end else if (bus.refresh && state != IDLE) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_driver.sv
// Self-checking bench for ws2812b_driver with a timeline-based reference model.
module tb_ws2812b_driver;
    import ws2812b_pkg::*;

    localparam int FRAME_CYC = 288 * 50;
    localparam int LATCH_CYC = 2400;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    ws2812b_if bus();

    ws2812b_driver dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current frame+latch sequence.
    bit         m_act;
    int         m_el;
    bit         m_pend;
    bit [287:0] m_bits;
    logic       exp_data = 1'b0;
    logic       exp_busy = 1'b1;

    task automatic load_frame();
        for (int b = 0; b < 288; b++) begin
            int led;
            led = b / 24;
            m_bits[b] = bus.led_mask[led] ? bus.intensity[7 - (b % 8)] : 1'b0;
        end
    endtask

    function automatic logic level_at(input int t);
        int bn, ph;
        bn = t / 50;
        ph = t % 50;
        return (ph < (m_bits[bn] ? 32 : 16));
    endfunction

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            m_act    = 1'b1;
            m_el     = FRAME_CYC;
            m_pend   = 1'b1;
            exp_data = 1'b0;
            exp_busy = 1'b1;
        end else if (!m_act) begin
            exp_data = 1'b0;
            exp_busy = 1'b0;
            if (bus.refresh) begin
                m_act = 1'b1;
                m_el  = 0;
                load_frame();
            end
        end else begin
            m_el++;
            exp_busy = 1'b1;
            exp_data = (m_el <= FRAME_CYC) ? level_at(m_el - 1) : 1'b0;
            if (m_el == FRAME_CYC + LATCH_CYC) begin
                if (m_pend || bus.refresh) begin
                    m_el   = 0;
                    m_pend = 1'b0;
                    load_frame();
                end else begin
                    m_act = 1'b0;
                end
            end else if (bus.refresh) begin
                m_pend = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.led_data !== exp_data) begin
                errors++;
                $display("FAIL led_data t=%0t got %b expected %b", $time, bus.led_data, exp_data);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL busy t=%0t got %b expected %b", $time, bus.busy, exp_busy);
            end
        end
    end

    // High-pulse width recorder; one entry per transmitted bit.
    int   pw[$];
    int   run = 0;
    logic prev = 1'b0;
    always @(negedge clk) begin
        if (bus.led_data === 1'b1) begin
            run = prev ? run + 1 : 1;
        end else if (prev) begin
            pw.push_back(run);
        end
        prev = (bus.led_data === 1'b1);
    end

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic check_frame(input string nm, input bit [287:0] ones);
        int bad;
        bad = 0;
        check({nm, "_pulses"}, pw.size(), 288);
        for (int i = 0; i < pw.size() && i < 288; i++) begin
            if (pw[i] != (ones[i] ? 32 : 16)) bad++;
        end
        check({nm, "_widths_bad"}, bad, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int el;
    task automatic advance_to(input int t);
        while (el < t) begin
            @(negedge clk);
            el++;
        end
    endtask

    task automatic pulse_refresh();
        bus.refresh = 1'b1;
        advance_to(el + 1);
        bus.refresh = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r, cnt, first_rise, noise_at, r1, r2, r3;
        bit [287:0] v;

        bus.refresh   = 1'b0;
        bus.led_mask  = '0;
        bus.intensity = '0;
        res_n         = 1'b0;
        tick(4);
        chk_en = 1'b1;
        check("reset_led_data", int'(bus.led_data), 0);
        check("reset_busy", int'(bus.busy), 1);

        // Auto frame after reset, interrupted by a reset during bit 100.
        #2 res_n = 1'b1;
        tick(2410);
        bus.led_mask  = 12'($urandom);
        bus.intensity = 8'($urandom);
        r = $urandom_range(1, 15);
        tick(4990 + r);
        check("pre_reset_high", int'(bus.led_data), 1);
        #2 res_n = 1'b0;
        #1;
        check("midreset_led_data", int'(bus.led_data), 0);
        check("midreset_busy", int'(bus.busy), 1);
        bus.led_mask  = '0;
        bus.intensity = '0;
        tick(2);
        #2 res_n = 1'b1;

        // Restarted sequence: latch gap, one all-zero frame, latch, idle.
        pw.delete();
        cnt        = 0;
        first_rise = 0;
        noise_at   = $urandom_range(2405, 14000);
        while (bus.busy !== 1'b0 && cnt < 25000) begin
            @(negedge clk);
            cnt++;
            if (cnt == noise_at) begin
                bus.led_mask  = 12'($urandom);
                bus.intensity = 8'($urandom);
            end
            if (first_rise == 0 && bus.led_data === 1'b1) first_rise = cnt;
        end
        check("first_rise_after_release", first_rise, 2401);
        check("busy_fall_after_release", cnt, 19201);
        v = '0;
        check_frame("zero_frame", v);

        // Frame with LED0 lit, three mid-frame refreshes and a mask change.
        tick(5);
        bus.led_mask  = 12'h001;
        bus.intensity = 8'h20;
        bus.refresh   = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        el = 0;
        pw.delete();
        check("accept_busy_lag", int'(bus.busy), 0);
        advance_to(1);
        check("first_high_edge", int'(bus.led_data), 1);
        check("busy_after_accept", int'(bus.busy), 1);
        r1 = $urandom_range(50, 5000);
        r2 = $urandom_range(r1 + 2, 10000);
        r3 = $urandom_range(r2 + 2, 16700);
        advance_to(r1);
        bus.led_mask  = 12'h002;
        bus.intensity = 8'h81;
        pulse_refresh();
        advance_to(r2);
        pulse_refresh();
        advance_to(r3);
        pulse_refresh();
        advance_to(14500);
        v = '0;
        v[2] = 1'b1; v[10] = 1'b1; v[18] = 1'b1;
        check_frame("led0_frame", v);
        pw.delete();

        advance_to(16800 + 14500);
        v = '0;
        v[24] = 1'b1; v[31] = 1'b1; v[32] = 1'b1;
        v[39] = 1'b1; v[40] = 1'b1; v[47] = 1'b1;
        check_frame("followup_led1_frame", v);
        pw.delete();

        // Refresh on the last latch cycle: back-to-back frame, LED11 at 0x01.
        bus.led_mask  = 12'h800;
        bus.intensity = 8'h01;
        advance_to(33599);
        bus.refresh = 1'b1;
        advance_to(33600);
        bus.refresh = 1'b0;
        check("busy_at_latch_end", int'(bus.busy), 1);
        advance_to(33601);
        check("back_to_back_high", int'(bus.led_data), 1);
        advance_to(33600 + 14500);
        v = '0;
        v[271] = 1'b1; v[279] = 1'b1; v[287] = 1'b1;
        check_frame("led11_frame", v);
        while (bus.busy !== 1'b0 && el < 33600 + 17000) advance_to(el + 1);
        check("busy_fall_final", el, 50401);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812b_driver.md
Name: ws2812b_driver

Overview:
- Downstream consumer of the rotary-encoder controller. Serializes the 12-LED ring image onto one WS2812B data line.
- Each frame is built from the controller's led_mask and intensity_out. The frame is re-sent when the controller pulses refresh.
- Runs on the 40 MHz system clock. Owns all WS2812B bit timing and the latch (reset) gap.

Parameters:
- N_LEDS, 12, LEDs on the ring; one mask bit per LED.
- T0H, 16, cycles high for a 0 bit (400 ns).
- T1H, 32, cycles high for a 1 bit (800 ns).
- TBIT, 50, total cycles per bit (1.25 us); low time is TBIT minus the high time.
- TLATCH, 2400, low cycles after a frame (60 us; the part needs more than 50 us).

Ports:
- clk  in  1  system clock, 40 MHz.
- res_n  in  1  asynchronous active-low reset.
- refresh  in  1  one-cycle request to send a new frame.
- led_mask  in  12  bit i set means LED i is lit.
- intensity  in  8  per-channel value for lit LEDs.
- led_data  out  1  WS2812B serial data, registered.
- busy  out  1  high while a frame or latch gap is in progress.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, res_n). While res_n is low:
  - led_data=0, busy=1.
  - State=LATCH, cycle counter=0, pending=1.
  - Snapshot registers cleared to 0.
- After reset release: a full TLATCH gap runs, then one frame is sent automatically because pending=1.
- States:
  - IDLE: busy=0, led_data=0. refresh high at edge k takes the snapshot at edge k and enters HIGH. led_data rises at edge k+1.
  - HIGH: led_data=1 for T1H or T0H cycles, depending on the current bit. Then enter LOW.
  - LOW: led_data=0 for the remaining TBIT cycles. Then advance to the next bit, or enter LATCH after the last bit.
  - LATCH: led_data=0 for TLATCH cycles. On its last cycle:
    - if pending or refresh: clear pending, take a new snapshot, go to HIGH;
    - else go to IDLE.
- Frame format:
  - N_LEDS x 24 bits, LED0 (mask bit 0) first.
  - Per LED, channel order G,R,B, each sent MSB first.
  - Lit LED: G=R=B=intensity snapshot. Unlit LED: all channels 0x00.
  - Frame length: 288 bits x 50 = 14400 cycles, then 2400 latch cycles.
- Snapshot: led_mask and intensity are captured only at frame start. Input changes during a frame do not affect the frame in flight.
- refresh while in HIGH, LOW or LATCH sets pending. Any number of such requests collapse into one follow-up frame.
- Counters:
  - bit counter 0..23 and LED counter 0..N_LEDS-1, no wrap beyond these ranges;
  - cycle counter wide enough for TLATCH (12 bits), cleared on every state change.
- Reset asserted mid-frame: led_data drops immediately. The partial frame is discarded. Sequencing restarts as described under Reset.
- busy: high from edge k+1 (after the accepted refresh) until the cycle that returns to IDLE.

Decomposition:
- Shared package ws2812b_pkg:
  - state enum (IDLE, HIGH, LOW, LATCH);
  - timing constants T0H, T1H, TBIT, TLATCH derived for 40 MHz;
  - BITS_PER_LED=24.
- Sub-module ws2812b_bit_encoder:
  - inputs: bit value and a start strobe;
  - outputs: the high/low waveform and a done pulse after TBIT cycles;
  - it owns the per-bit cycle counter.
- The top level keeps the frame sequencing, snapshot, pending flag and latch counter.

Test Plan:
- Reset release with no refresh -> led_data low for 2400 cycles. Then one frame with mask 0x000, intensity 0x00: all 288 bits are 16-high/34-low pulses. busy falls after 14400+2400 cycles.
- refresh with mask=0x001, intensity=0x20 -> the first 24 bits are 00100000 three times, where each 1 is 32 high/18 low. The remaining 264 bits are 0 pulses.
- mask=0x800, intensity=0x01 -> only bits 271, 279 and 287 (the LSB of each channel of LED11) are 1 pulses. Each is 32 high/18 low.
- Three refresh pulses during one frame, with mask changed from 0x001 to 0x002 mid-frame -> the current frame still lights LED0. Exactly one extra frame follows the latch and lights LED1. busy stays high continuously.
- res_n pulled low at bit 100 -> led_data is 0 in the same cycle. After release: a 2400-cycle gap, then a complete 288-bit frame.
- refresh coinciding with the last LATCH cycle -> the next frame's first high starts on the next edge, with no IDLE cycle and no busy drop.
